// File: rtl/frm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// frm_seq_ctrl -- frame sequencer controller
//
// Sequences a downstream frame converter through runs of frames. A run starts
// on sw_start, enables the converter (blk_en) for one frame at a time, and
// inserts a programmable idle gap between frames. A run ends after
// cfg_nr_frames frames (single-shot mode) or on sw_stop (continuous mode).
// An optional stall watchdog moves the sequencer to an error state when the
// monitored frame interface makes no progress for cfg_tmo cycles.
//
// Optional feature macro: FRM_SEQ_TMO_EN
//   defined   : stall counter, ERR state and sticky sts_tmo_err are built.
//   undefined : no stall counter, ERR unreachable, sts_tmo_err tied to 0,
//               cfg_tmo ignored.
//
// Ports
//   clk, rst_n          clock (rising edge) / asynchronous active-low reset
//   sw_start, sw_stop   software start / stop request pulses
//   cfg_continuous      1 = run until stopped, 0 = run cfg_nr_frames frames
//   cfg_nr_frames       frames per run (0 behaves as 1)
//   cfg_gap             idle cycles between frames (GAP_W bits)
//   cfg_tmo             stall limit in cycles, 0 = no timeout (TMO_W bits)
//   mon_frm_val/rdy/eof monitored frame interface valid / ready / end-of-frame
//   blk_en              converter enable, high only while a frame may run
//   sts_busy            high whenever the sequencer is not idle
//   sts_frm_cnt         frames completed in the current run (wraps at 256)
//   sts_tmo_err         sticky stall-timeout error
//   irq_frm_done        one-cycle pulse per completed frame
// -----------------------------------------------------------------------------
module frm_seq_ctrl #(
    parameter int GAP_W = 16,
    parameter int TMO_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sw_start,
    input  logic             sw_stop,
    input  logic             cfg_continuous,
    input  logic [7:0]       cfg_nr_frames,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic [TMO_W-1:0] cfg_tmo,
    input  logic             mon_frm_val,
    input  logic             mon_frm_rdy,
    input  logic             mon_frm_eof,
    output logic             blk_en,
    output logic             sts_busy,
    output logic [7:0]       sts_frm_cnt,
    output logic             sts_tmo_err,
    output logic             irq_frm_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_RUN  = 3'd2,
        S_GAP  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             hs;
    logic             eof_hs;
    logic             stop_lat;
    logic             stop_req;
    logic [7:0]       nr_eff;
    logic [7:0]       cnt_inc;
    logic             last_frm;
    logic [GAP_W-1:0] gap_cnt;
    logic             tmo_hit;

    assign hs      = mon_frm_val & mon_frm_rdy;
    assign eof_hs  = hs & mon_frm_eof;

    // A stop seen in the same cycle as the final handshake counts as well as
    // one latched earlier in the frame.
    assign stop_req = stop_lat | sw_stop;

    assign nr_eff   = (cfg_nr_frames == 8'd0) ? 8'd1 : cfg_nr_frames;
    assign cnt_inc  = sts_frm_cnt + 8'd1;
    assign last_frm = !cfg_continuous && (cnt_inc == nr_eff);

`ifdef FRM_SEQ_TMO_EN
    logic [TMO_W-1:0] stall_cnt;
    logic [TMO_W-1:0] stall_inc;

    assign stall_inc = (&stall_cnt) ? stall_cnt : stall_cnt + 1'b1;

    // Fire on the cycle whose increment would reach the limit, so blk_en is
    // high for exactly cfg_tmo stalled cycles. A handshake clears the count
    // instead, which also gives eof_hs priority over the timeout.
    assign tmo_hit = (cfg_tmo != '0) && !hs && (stall_inc >= cfg_tmo);

    // Held at zero outside RUN, so every entry to RUN starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (state != S_RUN || hs) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sts_tmo_err <= 1'b0;
        end else begin
            sts_tmo_err <= (state_nxt == S_ERR);
        end
    end
`else
    logic unused_tmo;

    assign unused_tmo  = ^cfg_tmo;
    assign tmo_hit     = 1'b0;
    assign sts_tmo_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                // start together with stop is treated as no request
                if (sw_start && !sw_stop) begin
                    state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                // single cycle with blk_en low guarantees a clean rising edge
                state_nxt = sw_stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (eof_hs) begin
                    state_nxt = (stop_req || last_frm) ? S_IDLE : S_GAP;
                end else if (tmo_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_GAP: begin
                if (stop_req) begin
                    state_nxt = S_IDLE;
                end else if (gap_cnt == '0) begin
                    state_nxt = S_RUN;
                end
            end
            S_ERR: begin
                if (sw_stop) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Gap counter: loaded on entry to GAP, counts down to zero. GAP always
    // lasts cfg_gap + 1 cycles, so blk_en drops for at least one cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (state != S_GAP && state_nxt == S_GAP) begin
            gap_cnt <= cfg_gap;
        end else if (state == S_GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stop latch: remembers a stop request until the current frame ends.
    // Held clear while idle, which also clears it for each new run.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_lat <= 1'b0;
        end else if (state == S_IDLE) begin
            stop_lat <= 1'b0;
        end else if (sw_stop) begin
            stop_lat <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame counter and completion interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sts_frm_cnt  <= 8'd0;
            irq_frm_done <= 1'b0;
        end else begin
            irq_frm_done <= (state == S_RUN) && eof_hs;
            if (state == S_IDLE && state_nxt == S_ARM) begin
                sts_frm_cnt <= 8'd0;
            end else if (state == S_RUN && eof_hs) begin
                sts_frm_cnt <= cnt_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered status outputs, decoded from the next state so that they
    // line up exactly with the state register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_en   <= 1'b0;
            sts_busy <= 1'b0;
        end else begin
            blk_en   <= (state_nxt == S_RUN);
            sts_busy <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: doc/frm_seq_ctrl.md
FRM_SEQ_CTRL -- requirements
Module: frm_seq_ctrl

Interface
REQ-001 SHALL have parameter GAP_W, default 16: inter-frame gap counter width.
REQ-002 SHALL have parameter TMO_W, default 24: stall timeout counter width.
REQ-003 SHALL have port clk, input, 1: system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous reset, active low.
REQ-005 SHALL have port sw_start, input, 1: start request pulse.
REQ-006 SHALL have port sw_stop, input, 1: stop request pulse.
REQ-007 SHALL have port cfg_continuous, input, 1: 1 = run until stopped; 0 = run cfg_nr_frames frames.
REQ-008 SHALL have port cfg_nr_frames, input, 8: frames per run; 0 is treated as 1.
REQ-009 SHALL have port cfg_gap, input, GAP_W: idle cycles between frames.
REQ-010 SHALL have port cfg_tmo, input, TMO_W: stall limit in cycles; 0 disables the timeout.
REQ-011 SHALL have ports mon_frm_val, mon_frm_rdy, mon_frm_eof, input, 1 each: monitored frame-interface valid, ready and end-of-frame.
REQ-012 SHALL have port blk_en, output, 1: block enable driven to the frame converter's cfg_blk_en.
REQ-013 SHALL have port sts_busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port sts_frm_cnt, output, 8: frames completed in the current run.
REQ-015 SHALL have port sts_tmo_err, output, 1: sticky timeout error.
REQ-016 SHALL have port irq_frm_done, output, 1: one-cycle pulse per completed frame.

Function
REQ-017 SHALL define hs = mon_frm_val & mon_frm_rdy, and eof_hs = hs & mon_frm_eof.
REQ-018 SHALL implement the registered FSM IDLE, ARM, RUN, GAP, ERR.
REQ-019 SHALL drive blk_en from a register that is high only in RUN; all outputs are registered.
REQ-020 SHALL, in IDLE on sw_start with sw_stop low: clear sts_frm_cnt, clear the stop latch, go to ARM; sw_start and sw_stop together SHALL leave the FSM in IDLE.
REQ-021 SHALL stay in ARM for exactly 1 cycle, then go to RUN, so blk_en has a guaranteed rising edge 2 cycles after sw_start is sampled.
REQ-022 SHALL, in RUN on eof_hs: increment sts_frm_cnt (modulo 256) and pulse irq_frm_done the next cycle.
REQ-023 SHALL, on that same eof_hs, go to IDLE if the stop latch is set or (cfg_continuous = 0 and the new count equals cfg_nr_frames); otherwise go to GAP.
REQ-024 SHALL, on entering GAP, load the gap counter with cfg_gap and decrement it each cycle; at 0 it SHALL go to RUN.
REQ-025 SHALL keep blk_en low for at least 1 cycle in GAP, including when cfg_gap = 0.
REQ-026 SHALL set a stop latch on sw_stop in any non-IDLE state; in ARM or GAP the FSM SHALL go to IDLE next cycle; in RUN the current frame SHALL complete first.
REQ-027 SHALL ignore sw_start outside IDLE.
REQ-028 SHALL clear the stall counter on entry to RUN and on every hs, and increment it (saturating) in RUN otherwise.
REQ-029 SHALL, when cfg_tmo != 0 and the stall counter reaches cfg_tmo, go to ERR, set sts_tmo_err and drop blk_en.
REQ-030 SHALL hold ERR until sw_stop, then go to IDLE and clear sts_tmo_err; sw_start in ERR is ignored.
REQ-031 SHALL give eof_hs priority over the timeout when both occur in the same cycle.

Reset
REQ-032 SHALL, while rst_n is low: force state IDLE and drive blk_en, sts_busy, sts_tmo_err and irq_frm_done to 0 and sts_frm_cnt to 0.
REQ-033 SHALL clear all counters and the stop latch on reset, and abort any frame in progress without an irq_frm_done pulse.

Configuration
REQ-034 SHALL, with macro FRM_SEQ_TMO_EN defined, implement the stall counter, the ERR state and sts_tmo_err per REQ-028..031.
REQ-035 SHALL, without FRM_SEQ_TMO_EN, omit the stall counter, make ERR unreachable, tie sts_tmo_err to 0 and ignore cfg_tmo.

Verification
REQ-036 SHALL cover: cfg_continuous=0, cfg_nr_frames=3, cfg_gap=4, sw_start -> 3 blk_en high periods each separated by ≥5 low cycles, 3 irq pulses, sts_frm_cnt=3, then IDLE.
REQ-037 SHALL cover: cfg_continuous=1, sw_stop mid-frame 2 -> frame 2 completes, sts_frm_cnt=2, IDLE with no further blk_en.
REQ-038 SHALL cover: cfg_tmo=16, mon_frm_rdy held low in RUN -> ERR after 16 cycles, blk_en=0, sts_tmo_err=1; sw_stop -> IDLE, sts_tmo_err=0.
REQ-039 SHALL cover: cfg_gap=0 -> blk_en low for exactly 1 cycle between frames.
REQ-040 SHALL cover: sw_start and sw_stop in the same cycle in IDLE -> FSM stays in IDLE.
REQ-041 SHALL cover: rst_n asserted mid-RUN -> all outputs 0 asynchronously, no irq pulse.
